// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin two-master arbiter for a single-port RAM with bounded lock bursts.
// Define ARB_CPU_PRIORITY_EN to make master 0 win every contention (lock bursts still honoured).
module ram_port_arbiter #(
  parameter int SIZE = 14,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            lock0,
  input  logic            we0,
  input  logic [SIZE-1:0] addr0,
  input  logic [31:0]     wdata0,
  output logic            gnt0,
  output logic            rvalid0,
  output logic [31:0]     rdata0,
  input  logic            req1,
  input  logic            lock1,
  input  logic            we1,
  input  logic [SIZE-1:0] addr1,
  input  logic [31:0]     wdata1,
  output logic            gnt1,
  output logic            rvalid1,
  output logic [31:0]     rdata1,
  output logic            wrEn,
  output logic [SIZE-1:0] addr_toRAM,
  output logic [31:0]     data_toRAM,
  input  logic [31:0]     data_fromRAM
);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state;
  logic last;
  logic [CW-1:0] burst_cnt;
  logic rv0, rv1;
  logic sat, hold0, hold1, pick0, own_g;
  always_comb begin
    sat = burst_cnt >= CW'(MAX_BURST);
    hold0 = state == OWN0 && req0 && lock0 && (!sat || !req1);
    hold1 = state == OWN1 && req1 && lock1 && (!sat || !req0);
`ifdef ARB_CPU_PRIORITY_EN
    pick0 = 1'b1;
`else
    pick0 = last;
`endif
    gnt0 = hold0 | (~hold1 & req0 & (~req1 | pick0));
    gnt1 = req1 & ~gnt0;
    wrEn = ~rst & (gnt0 ? we0 : gnt1 & we1);
    addr_toRAM = gnt0 ? addr0 : gnt1 ? addr1 : '0;
    data_toRAM = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
    own_g = (gnt0 && state == OWN0) || (gnt1 && state == OWN1);
    // a read return pending across reset is discarded in the reset cycle itself
    rvalid0 = rv0 & ~rst;
    rvalid1 = rv1 & ~rst;
    rdata0 = rvalid0 ? data_fromRAM : '0;
    rdata1 = rvalid1 ? data_fromRAM : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      burst_cnt <= '0;
      rv0 <= 1'b0;
      rv1 <= 1'b0;
    end else begin
      state <= gnt0 ? OWN0 : gnt1 ? OWN1 : IDLE;
      last <= gnt0 ? 1'b0 : gnt1 ? 1'b1 : last;
      burst_cnt <= !(gnt0 | gnt1) ? '0 : !own_g ? CW'(1) : sat ? burst_cnt : burst_cnt + CW'(1);
      rv0 <= gnt0 & ~we0;
      rv1 <= gnt1 & ~we1;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed plan checks plus randomized traffic against a behavioural arbiter/RAM model.
module tb_ram_port_arbiter;
  localparam int SIZE = 14;
  localparam int MAX_BURST = 4;
  localparam int DEPTH = 1 << SIZE;
`ifdef ARB_CPU_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, req0, lock0, we0, req1, lock1, we1;
  logic [SIZE-1:0] addr0, addr1, addr_toRAM;
  logic [31:0] wdata0, wdata1, rdata0, rdata1, data_toRAM, data_fromRAM;
  logic gnt0, gnt1, rvalid0, rvalid1, wrEn;
  int checks = 0, failures = 0;
  bit active = 1'b0;
  logic [31:0] ram [DEPTH];
  bit wr_ok [DEPTH];
  logic [31:0] mdl [DEPTH];
  int m_own = -1, m_last = 1, m_cnt = 0;
  bit m_rv [2];
  logic [31:0] m_rd [2];

  ram_port_arbiter #(.SIZE(SIZE), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .wrEn(wrEn), .addr_toRAM(addr_toRAM), .data_toRAM(data_toRAM), .data_fromRAM(data_fromRAM)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [SIZE-1:0] a);
    return a == SIZE'(5) ? 32'hDEADBEEF : {18'h0, a} * 32'h9E3779B9 + 32'h1234;
  endfunction

  always @(posedge clk) begin
    if (wrEn) begin
      ram[addr_toRAM] <= data_toRAM;
      wr_ok[addr_toRAM] <= 1'b1;
    end
    data_fromRAM <= wr_ok[addr_toRAM] ? ram[addr_toRAM] : init_val(addr_toRAM);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // behavioural model: decide the grant from the arbitration rules, then advance ownership/memory
  always @(negedge clk) if (active) begin
    bit rq [2], lk [2], wq [2], hold, rv_now;
    logic [SIZE-1:0] ad [2];
    logic [31:0] wd [2];
    int eg;
    rq[0] = req0; rq[1] = req1; lk[0] = lock0; lk[1] = lock1; wq[0] = we0; wq[1] = we1;
    ad[0] = addr0; ad[1] = addr1; wd[0] = wdata0; wd[1] = wdata1;
    hold = m_own >= 0 ? (rq[m_own] && lk[m_own] && (m_cnt < MAX_BURST || !rq[1-m_own])) : 1'b0;
    eg = hold ? m_own : (rq[0] && rq[1]) ? (PRIO ? 0 : 1 - m_last) : rq[0] ? 0 : rq[1] ? 1 : -1;
    chk("gnt0", 32'(gnt0), 32'(eg == 0));
    chk("gnt1", 32'(gnt1), 32'(eg == 1));
    chk("wrEn", 32'(wrEn), 32'(eg >= 0 ? (!rst && wq[eg]) : 1'b0));
    chk("addr_toRAM", 32'(addr_toRAM), eg >= 0 ? 32'(ad[eg]) : 32'h0);
    chk("data_toRAM", data_toRAM, eg >= 0 ? wd[eg] : 32'h0);
    rv_now = m_rv[0] && !rst;
    chk("rvalid0", 32'(rvalid0), 32'(rv_now));
    chk("rdata0", rdata0, rv_now ? m_rd[0] : 32'h0);
    rv_now = m_rv[1] && !rst;
    chk("rvalid1", 32'(rvalid1), 32'(rv_now));
    chk("rdata1", rdata1, rv_now ? m_rd[1] : 32'h0);
    m_rv[0] = 1'b0;
    m_rv[1] = 1'b0;
    if (rst) begin
      m_own = -1; m_last = 1; m_cnt = 0;
    end else if (eg >= 0) begin
      m_cnt = (m_own == eg) ? (m_cnt < MAX_BURST ? m_cnt + 1 : m_cnt) : 1;
      m_own = eg;
      m_last = eg;
      if (wq[eg]) mdl[ad[eg]] = wd[eg];
      else begin
        m_rv[eg] = 1'b1;
        m_rd[eg] = mdl[ad[eg]];
      end
    end else begin
      m_own = -1; m_cnt = 0;
    end
  end

  initial begin
    bit g0, g1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = init_val(SIZE'(i));
    rst = 1'b1;
    {req0, lock0, we0, req1, lock1, we1} = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    @(posedge clk); #1;
    active = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("reset_gnt0", 32'(gnt0), 32'd0);
    chk("reset_rvalid0", 32'(rvalid0), 32'd0);
    chk("reset_wrEn", 32'(wrEn), 32'd0);
    chk("reset_addr", 32'(addr_toRAM), 32'd0);
    step(); req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0005;
    @(negedge clk);
    chk("rd5_gnt0", 32'(gnt0), 32'd1);
    chk("rd5_addr", 32'(addr_toRAM), 32'h5);
    chk("rd5_wrEn", 32'(wrEn), 32'd0);
    step(); req0 = 1'b0;
    @(negedge clk);
    chk("rd5_rvalid0", 32'(rvalid0), 32'd1);
    chk("rd5_rdata0", rdata0, 32'hDEADBEEF);
    step(); req1 = 1'b1; we1 = 1'b1; addr1 = 14'h0010; wdata1 = 32'h12345678;
    @(negedge clk);
    chk("wr_gnt1", 32'(gnt1), 32'd1);
    chk("wr_wrEn", 32'(wrEn), 32'd1);
    chk("wr_addr", 32'(addr_toRAM), 32'h10);
    chk("wr_data", data_toRAM, 32'h12345678);
    step(); req1 = 1'b0; we1 = 1'b0;
    @(negedge clk);
    chk("wr_no_rvalid1", 32'(rvalid1), 32'd0);
    step(); req1 = 1'b1;
    @(negedge clk);
    chk("rd10_gnt1", 32'(gnt1), 32'd1);
    step(); req1 = 1'b0;
    @(negedge clk);
    chk("rd10_rvalid1", 32'(rvalid1), 32'd1);
    chk("rd10_rdata1", rdata1, 32'h12345678);
    step(); req0 = 1'b1; req1 = 1'b1; addr0 = 14'h1; addr1 = 14'h2;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      @(negedge clk);
      chk("contend_gnt0", 32'(gnt0), 32'(PRIO ? 1'b1 : k % 2 == 0));
    end
    step(); req0 = 1'b0; req1 = 1'b0;
    step(); req1 = 1'b1; lock1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin step(); req0 = 1'b1; end
      @(negedge clk);
      chk("burst_gnt1", 32'(gnt1), 32'(k < 4));
    end
    for (int k = 0; k < 6; k++) begin
      step(); req0 = 1'b0;
      @(negedge clk);
      chk("burst_solo_gnt1", 32'(gnt1), 32'd1);
    end
    step(); req1 = 1'b0; lock1 = 1'b0;
    step(); req0 = 1'b1; addr0 = 14'h5;
    @(negedge clk);
    chk("rstrd_gnt0", 32'(gnt0), 32'd1);
    step(); req0 = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstrd_rvalid0", 32'(rvalid0), 32'd0);
    chk("rstrd_rdata0", rdata0, 32'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid0", 32'(rvalid0), 32'd0);
    step(); req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt0", 32'(gnt0), 32'd1);
    chk("post_rst_gnt1", 32'(gnt1), 32'd0);
    step(); req0 = 1'b0; req1 = 1'b0;
    g0 = 1'b1; g1 = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      step();
      rst = $urandom_range(0, 199) == 0;
      if (g0 || !req0) begin
        req0 = $urandom_range(0, 3) != 0;
        lock0 = $urandom_range(0, 2) == 0;
        we0 = $urandom_range(0, 2) == 0;
        addr0 = SIZE'($urandom_range(0, 31));
        wdata0 = $urandom;
      end
      if (g1 || !req1) begin
        req1 = $urandom_range(0, 3) != 0;
        lock1 = $urandom_range(0, 1) == 0;
        we1 = $urandom_range(0, 2) == 0;
        addr1 = SIZE'($urandom_range(0, 31));
        wdata1 = $urandom;
      end
      @(negedge clk);
      g0 = gnt0;
      g1 = gnt1;
    end
    step();
    active = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
